// File: rtl/sfixed_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sfixed_pkg
//  Brief    : Shared signed fixed-point helpers (format sizing, divider
//             shift/iteration derivation, saturation limits, FSM encoding).
//  Revision : 1.0 - initial release
// ============================================================================
package sfixed_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } div_state_t;

    // Total width of a signed Qleft.right value, sign bit included.
    function automatic int sfixed_size(input int left, input int right);
        return left + right + 1;
    endfunction

    // Left alignment of the dividend so the quotient lands on the output grid.
    function automatic int sfixed_div_shift(input int a_right, input int b_right,
                                            input int out_right);
        return out_right + b_right - a_right;
    endfunction

    function automatic int sfixed_div_nw(input int a_size, input int shift);
        return a_size + shift;
    endfunction

    function automatic longint sfixed_max(input int size);
        return (64'sd1 <<< (size - 1)) - 64'sd1;
    endfunction

    function automatic longint sfixed_min(input int size);
        return -(64'sd1 <<< (size - 1));
    endfunction

endpackage
`default_nettype wire

// File: rtl/sfixed_saturate.sv
`default_nettype none
// ============================================================================
//  Module   : sfixed_saturate
//  Brief    : Converts an unsigned magnitude plus sign into a saturated
//             two's-complement value of OUT_SIZE bits with an overflow flag.
//  Revision : 1.0 - initial release
// ============================================================================
module sfixed_saturate
    import sfixed_pkg::*;
#(
    parameter int MAG_W    = 16,
    parameter int OUT_SIZE = 8
) (
    input  logic [MAG_W-1:0]           i_mag,
    input  logic                       i_neg,
    output logic signed [OUT_SIZE-1:0] o_q,
    output logic                       o_ovf
);

    // One spare bit so the negative limit (2^(OUT_SIZE-1)) is always representable.
    localparam int CW = ((MAG_W > OUT_SIZE) ? MAG_W : OUT_SIZE) + 1;

    localparam logic [CW-1:0]       c_pos_lim = CW'(sfixed_max(OUT_SIZE));
    localparam logic [CW-1:0]       c_neg_lim = c_pos_lim + CW'(1);
    localparam logic [OUT_SIZE-1:0] c_q_max   = OUT_SIZE'(sfixed_max(OUT_SIZE));
    localparam logic [OUT_SIZE-1:0] c_q_min   = OUT_SIZE'(sfixed_min(OUT_SIZE));

    logic [CW-1:0]       w_mag;
    logic [OUT_SIZE-1:0] w_low;

    always_comb begin
        w_mag = CW'(i_mag);
        w_low = w_mag[OUT_SIZE-1:0];
        o_ovf = i_neg ? (w_mag > c_neg_lim) : (w_mag > c_pos_lim);
        if (o_ovf) begin
            o_q = i_neg ? c_q_min : c_q_max;
        end else begin
            o_q = i_neg ? -w_low : w_low;
        end
    end

endmodule
`default_nettype wire

// File: rtl/sfixed_div_seq.sv
`default_nettype none
// ============================================================================
//  Module   : sfixed_div_seq
//  Brief    : Sequential signed fixed-point divider, one quotient bit per
//             clock (restoring division on magnitudes), saturating output.
//  Revision : 1.0 - initial release
// ============================================================================
module sfixed_div_seq
    import sfixed_pkg::*;
#(
    parameter int A_LEFT    = 7,
    parameter int A_RIGHT   = 8,
    parameter int B_LEFT    = 3,
    parameter int B_RIGHT   = 4,
    parameter int OUT_LEFT  = 3,
    parameter int OUT_RIGHT = 4,
    localparam int A_SIZE   = sfixed_size(A_LEFT, A_RIGHT),
    localparam int B_SIZE   = sfixed_size(B_LEFT, B_RIGHT),
    localparam int OUT_SIZE = sfixed_size(OUT_LEFT, OUT_RIGHT)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic signed [A_SIZE-1:0]   a,
    input  logic signed [B_SIZE-1:0]   b,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic signed [OUT_SIZE-1:0] out_q,
    output logic                       overflow,
    output logic                       div_by_zero
);

    localparam int SHIFT = sfixed_div_shift(A_RIGHT, B_RIGHT, OUT_RIGHT);
    localparam int NW    = sfixed_div_nw(A_SIZE, SHIFT);
    localparam int CNT_W = (NW > 1) ? $clog2(NW) : 1;

    localparam logic [OUT_SIZE-1:0] c_q_max = OUT_SIZE'(sfixed_max(OUT_SIZE));
    localparam logic [OUT_SIZE-1:0] c_q_min = OUT_SIZE'(sfixed_min(OUT_SIZE));

    generate
        if (SHIFT < 0) begin : g_bad_shift
            $error("sfixed_div_seq: OUT_RIGHT+B_RIGHT must be >= A_RIGHT");
        end
    endgenerate

    div_state_t          r_state;
    logic [NW-1:0]       r_n;
    logic [NW-1:0]       r_q;
    logic [B_SIZE-1:0]   r_d;
    logic [B_SIZE-1:0]   r_r;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_sign;
    logic                r_a_neg;
    logic                r_dbz;
    logic                r_iter_done;

    logic [A_SIZE-1:0]   w_a_mag;
    logic [B_SIZE-1:0]   w_b_mag;
    logic [B_SIZE:0]     w_r_shift;
    logic                w_ge;
    logic [OUT_SIZE-1:0] w_sat_q;
    logic                w_sat_ovf;

    assign in_ready = (r_state == ST_IDLE);

    // Magnitudes as unsigned: the most negative operand maps to 2^(size-1).
    assign w_a_mag   = a[A_SIZE-1] ? A_SIZE'(-a) : A_SIZE'(a);
    assign w_b_mag   = b[B_SIZE-1] ? B_SIZE'(-b) : B_SIZE'(b);
    assign w_r_shift = {r_r, r_n[NW-1]};
    assign w_ge      = (w_r_shift >= {1'b0, r_d});

    sfixed_saturate #(
        .MAG_W    (NW),
        .OUT_SIZE (OUT_SIZE)
    ) u_sat (
        .i_mag (r_q),
        .i_neg (r_sign),
        .o_q   (w_sat_q),
        .o_ovf (w_sat_ovf)
    );

    // A zero divisor skips the iterations but still takes the finalize edge,
    // so its result appears one edge after accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_n         <= '0;
            r_q         <= '0;
            r_d         <= '0;
            r_r         <= '0;
            r_cnt       <= '0;
            r_sign      <= 1'b0;
            r_a_neg     <= 1'b0;
            r_dbz       <= 1'b0;
            r_iter_done <= 1'b0;
            out_valid   <= 1'b0;
            out_q       <= '0;
            overflow    <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_sign      <= a[A_SIZE-1] ^ b[B_SIZE-1];
                        r_a_neg     <= a[A_SIZE-1];
                        r_n         <= NW'(w_a_mag) << SHIFT;
                        r_d         <= w_b_mag;
                        r_r         <= '0;
                        r_q         <= '0;
                        r_cnt       <= CNT_W'(NW - 1);
                        r_dbz       <= (b == '0);
                        r_iter_done <= (b == '0);
                        r_state     <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    if (r_iter_done) begin
                        out_valid <= 1'b1;
                        if (r_dbz) begin
                            out_q       <= r_a_neg ? c_q_min : c_q_max;
                            overflow    <= 1'b0;
                            div_by_zero <= 1'b1;
                        end else begin
                            out_q       <= w_sat_q;
                            overflow    <= w_sat_ovf;
                            div_by_zero <= 1'b0;
                        end
                        r_state <= ST_DONE;
                    end else begin
                        if (w_ge) begin
                            r_r <= B_SIZE'(w_r_shift - {1'b0, r_d});
                        end else begin
                            r_r <= B_SIZE'(w_r_shift);
                        end
                        r_q <= {r_q[NW-2:0], w_ge};
                        r_n <= r_n << 1;
                        if (r_cnt == '0) begin
                            r_iter_done <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt - CNT_W'(1);
                        end
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid   <= 1'b0;
                        out_q       <= '0;
                        overflow    <= 1'b0;
                        div_by_zero <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
